wavetable_bank_arb: RTL and testbench

- Parametrised successor to the per-oscillator four-bank wave RAM arbiter.
- Holds NBANKS wavetables of 2^ADDR_W words each and serves one oscillator read port plus one loader write port.
- Adds bank changes that take effect only at table wrap, so no cycle mixes two tables.
- Adds write protection for the playing and pending banks, and an idle-timeout swap for stopped oscillators.

---
 rtl/wavetable_pkg.sv | 28 ++
 rtl/wavetable_bank_arb_if.sv | 38 +++
 rtl/wavetable_bank_ram.sv | 25 ++
 rtl/wavetable_bank_arb.sv | 125 ++++++++++++
 tb/tb_wavetable_bank_arb.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wavetable_pkg.sv
// Shared defaults, bank index type, bank FSM encoding and a clog2 helper.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wavetable_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 8;
  localparam int NBANKS_DEF = 4;

  // Ceiling log2 usable in parameter expressions; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int BANK_W_DEF = clog2(NBANKS_DEF);

  typedef logic [BANK_W_DEF-1:0] bank_t;

  // Bank selection state: nothing waiting, or a request waiting for a wrap.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } bank_st_e;

endpackage

// File: rtl/wavetable_bank_arb_if.sv
// Groups the oscillator read port, loader write port and bank control.
// Latency: n/a (wires only).
// Backpressure: none; writes are answered by ack/rej strobes.
interface wavetable_bank_arb_if
  import wavetable_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NBANKS = NBANKS_DEF
);
  localparam int BANK_W = clog2(NBANKS);

  logic              wr_valid;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic              wr_rej;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [BANK_W-1:0] bank_sel;
  logic              bank_sel_valid;
  logic [BANK_W-1:0] bank_active;
  logic              swap_pending;

  modport master (
    output wr_valid, wr_bank, wr_addr, wr_data, rd_en, rd_addr, bank_sel, bank_sel_valid,
    input  wr_ack, wr_rej, rd_data, rd_valid, bank_active, swap_pending
  );

  modport slave (
    input  wr_valid, wr_bank, wr_addr, wr_data, rd_en, rd_addr, bank_sel, bank_sel_valid,
    output wr_ack, wr_rej, rd_data, rd_valid, bank_active, swap_pending
  );

endinterface

// File: rtl/wavetable_bank_ram.sv
// Simple dual-port sample RAM holding all banks back to back.
// Latency: 1 cycle registered read; write lands on the clock edge.
// Backpressure: none; read data register holds when re_i is low.
module wavetable_bank_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [0:(1<<AW)-1];

  // Block-RAM style port pair, intentionally without reset.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/wavetable_bank_arb.sv
// Wavetable bank arbiter: wrap-aligned bank swaps, write protection, idle swap.
// Latency: read data 2 cycles after rd_en; write ack/rej 1 cycle after wr_valid.
// Backpressure: none; writes to the playing or pending bank are rejected.
module wavetable_bank_arb
  import wavetable_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int NBANKS      = NBANKS_DEF,
  parameter int IDLE_CYCLES = 4096
) (
  input logic                 clk,
  input logic                 rst_n,
  wavetable_bank_arb_if.slave bus
);

  localparam int BANK_W = clog2(NBANKS);
  localparam int CNT_W  = clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

  bank_st_e          state_q, state_d;
  logic [BANK_W-1:0] active_q, active_d;
  logic [BANK_W-1:0] pend_q, pend_d;
  logic [BANK_W-1:0] bank_used;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic              wrap_swap, idle_swap, do_swap;
  logic              wr_hit, wr_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_pipe_q, rd_valid_q, wr_ack_q, wr_rej_q;

  // Swap triggers, read bank steering, write protection and idle count.
  always_comb begin
    wrap_swap = (state_q == ST_PENDING) && bus.rd_en && (bus.rd_addr == '0);
    idle_swap = (state_q == ST_PENDING) && !bus.rd_en && (idle_q == IDLE_LAST);
    do_swap   = wrap_swap || idle_swap;
    // The wrap read already fetches word 0 of the incoming table.
    bank_used = wrap_swap ? pend_q : active_q;
    wr_hit    = (bus.wr_bank == active_q) ||
                ((state_q == ST_PENDING) && (bus.wr_bank == pend_q));
    wr_we     = bus.wr_valid && !wr_hit;
    idle_d    = idle_q;
    if (bus.rd_en)              idle_d = '0;
    else if (idle_q != IDLE_LAST) idle_d = idle_q + 1'b1;
  end

  // Bank FSM next state: a request landing on a swap cycle stays pending.
  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    pend_d   = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.bank_sel_valid && (bus.bank_sel != active_q)) begin
          pend_d  = bus.bank_sel;
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (do_swap) begin
          active_d = pend_q;
          state_d  = ST_IDLE;
        end
        if (bus.bank_sel_valid) begin
          pend_d  = bus.bank_sel;
          state_d = ST_PENDING;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Bank state and idle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      pend_q   <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      idle_q   <= idle_d;
    end
  end

  wavetable_bank_ram #(
    .DATA_W (DATA_W),
    .AW     (BANK_W + ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_we),
    .waddr_i ({bus.wr_bank, bus.wr_addr}),
    .wdata_i (bus.wr_data),
    .re_i    (bus.rd_en),
    .raddr_i ({bank_used, bus.rd_addr}),
    .rdata_o (ram_rdata)
  );

  // Output stage: second read pipeline stage plus write response strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      wr_ack_q   <= 1'b0;
      wr_rej_q   <= 1'b0;
    end else begin
      rd_pipe_q  <= bus.rd_en;
      rd_valid_q <= rd_pipe_q;
      if (rd_pipe_q) rd_data_q <= ram_rdata;
      wr_ack_q   <= wr_we;
      wr_rej_q   <= bus.wr_valid && wr_hit;
    end
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.wr_ack       = wr_ack_q;
  assign bus.wr_rej       = wr_rej_q;
  assign bus.bank_active  = active_q;
  assign bus.swap_pending = (state_q == ST_PENDING);

endmodule

// File: tb/tb_wavetable_bank_arb.sv
// Scoreboard bench for wavetable_bank_arb with a table-level reference model.
// Latency: checks 2-cycle reads and 1-cycle write responses.
// Backpressure: none exercised; every strobe expects exactly one response.
module tb_wavetable_bank_arb;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int NB    = 4;
  localparam int BW    = 2;
  localparam int DEPTH = 256;
  localparam int IDLE  = 4096;

  typedef struct {
    bit        known;
    logic [15:0] data;
  } exp_rd_t;

  logic clk = 1'b0;
  logic rst_n;

  wavetable_bank_arb_if #(.DATA_W(DW), .ADDR_W(AW), .NBANKS(NB)) bus ();

  wavetable_bank_arb #(
    .DATA_W(DW), .ADDR_W(AW), .NBANKS(NB), .IDLE_CYCLES(IDLE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  int rej_cnt = 0;

  // Reference model: tables, which words are known, and the bank choice.
  logic [15:0] m_ram   [0:NB*DEPTH-1];
  bit          m_known [0:NB*DEPTH-1];
  int  m_active, m_pend, m_idle;
  bit  m_pv;

  exp_rd_t exp_rd [$];
  bit      exp_wr [$];
  exp_rd_t mon_e;
  bit      mon_r;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: response with no pending expectation", name);
  endtask

  // Advance one cycle: predict responses from the current inputs, then clock.
  task automatic tick();
    bit rej, swap;
    int idx, used, pre_active;
    bit pre_pv;
    exp_rd_t e;
    if (bus.wr_valid) begin
      rej = (int'(bus.wr_bank) == m_active) || (m_pv && int'(bus.wr_bank) == m_pend);
      exp_wr.push_back(rej);
      if (!rej) begin
        idx = int'(bus.wr_bank) * DEPTH + int'(bus.wr_addr);
        m_ram[idx]   = bus.wr_data;
        m_known[idx] = 1'b1;
      end
    end
    swap = m_pv && (bus.rd_en ? (bus.rd_addr == 0) : (m_idle >= IDLE - 1));
    if (bus.rd_en) begin
      used    = swap ? m_pend : m_active;
      idx     = used * DEPTH + int'(bus.rd_addr);
      e.known = m_known[idx];
      e.data  = m_ram[idx];
      exp_rd.push_back(e);
    end
    pre_active = m_active;
    pre_pv     = m_pv;
    if (swap) begin
      m_active = m_pend;
      m_pv     = 1'b0;
    end
    if (bus.bank_sel_valid && (pre_pv || int'(bus.bank_sel) != pre_active)) begin
      m_pend = int'(bus.bank_sel);
      m_pv   = 1'b1;
    end
    m_idle = bus.rd_en ? 0 : m_idle + 1;
    @(posedge clk);
    #1;
    check("bank_active", int'(bus.bank_active), m_active);
    check("swap_pending", int'(bus.swap_pending), int'(m_pv));
    bus.wr_valid       = 1'b0;
    bus.rd_en          = 1'b0;
    bus.bank_sel_valid = 1'b0;
  endtask

  task automatic wr(input int b, input int a, input int d);
    bus.wr_valid = 1'b1;
    bus.wr_bank  = BW'(b);
    bus.wr_addr  = AW'(a);
    bus.wr_data  = DW'(d);
    tick();
  endtask

  task automatic rd(input int a);
    bus.rd_en   = 1'b1;
    bus.rd_addr = AW'(a);
    tick();
  endtask

  task automatic sel(input int b);
    bus.bank_sel_valid = 1'b1;
    bus.bank_sel       = BW'(b);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rd_data", int'(bus.rd_data), 0);
    check("rst_rd_valid", int'(bus.rd_valid), 0);
    check("rst_wr_ack", int'(bus.wr_ack), 0);
    check("rst_wr_rej", int'(bus.wr_rej), 0);
    check("rst_bank_active", int'(bus.bank_active), 0);
    check("rst_swap_pending", int'(bus.swap_pending), 0);
    exp_rd.delete();
    exp_wr.delete();
    m_active = 0;
    m_pend   = 0;
    m_pv     = 1'b0;
    m_idle   = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pop and compare whenever the DUT presents a response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_ack && bus.wr_rej) begin
        fail("wr_ack_and_rej");
      end else if (bus.wr_ack || bus.wr_rej) begin
        if (bus.wr_ack) ack_cnt++;
        else            rej_cnt++;
        if (exp_wr.size() == 0) fail("wr_resp");
        else begin
          mon_r = exp_wr.pop_front();
          check("wr_rej", int'(bus.wr_rej), int'(mon_r));
        end
      end
      if (bus.rd_valid) begin
        if (exp_rd.size() == 0) fail("rd_valid");
        else begin
          mon_e = exp_rd.pop_front();
          if (mon_e.known) check("rd_data", int'(bus.rd_data), int'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ph, len;
    rst_n = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_bank = '0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.bank_sel = '0; bus.bank_sel_valid = 1'b0;
    #3;
    do_reset();

    // Load bank 1 with addr, bank 2 with 0x8000+addr, random idle gaps.
    for (int b = 1; b <= 2; b++)
      for (int a = 0; a < DEPTH; a++) begin
        wr(b, a, (b == 1) ? a : 16'h8000 + a);
        if ($urandom_range(0, 3) == 0) tick();
      end
    tick(); tick();
    check("load_ack_cnt", ack_cnt, 512);
    check("load_rej_cnt", rej_cnt, 0);
    for (int a = 0; a < DEPTH; a++) wr(3, a, 16'h4000 + a);
    wr(0, 9, 16'hBAD0);

    // Idle swap: one read clears the count, then request and stay idle.
    rd(7);
    sel(1);
    n = 1;
    while (bus.bank_active != 2'd1 && n < IDLE + 16) begin
      tick();
      n++;
    end
    check("idle_swap_cycles", n, IDLE);

    // Fill bank 0 while bank 1 plays; RAM must survive the next reset.
    for (int a = 0; a < DEPTH; a++) wr(0, a, 16'hC000 + a);
    wr(1, 4, 16'hDEAD);
    do_reset();

    // Read latency after reset.
    rd(5);
    check("lat_t1_valid", int'(bus.rd_valid), 0);
    tick();
    check("lat_t2_valid", int'(bus.rd_valid), 1);
    check("lat_t2_data", int'(bus.rd_data), 16'hC005);
    tick();
    check("lat_t3_valid", int'(bus.rd_valid), 0);
    check("lat_t3_hold", int'(bus.rd_data), 16'hC005);

    // Wrap-aligned swap to bank 1 during a sweep from 100.
    sel(1);
    for (int a = 100; a < DEPTH + 21; a++) begin
      rd(a % DEPTH);
      if (a == DEPTH) begin
        check("wrap_active", int'(bus.bank_active), 1);
        check("wrap_pending", int'(bus.swap_pending), 0);
      end
    end

    // Protection and last-wins: request 0 then 2, probe writes, then wrap.
    sel(0);
    sel(2);
    wr(1, 252, 16'hDEAD);
    wr(2, 0, 16'hBEEF);
    wr(3, 17, 16'h1234);
    wr(0, 3, 16'h5555);
    for (int a = 250; a < DEPTH + 11; a++) rd(a % DEPTH);
    check("last_wins_active", int'(bus.bank_active), 2);
    rd(0);
    tick();
    check("reject_kept_data", int'(bus.rd_data), 16'h8000);

    // Randomized traffic around a moving playhead.
    ph = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        bus.rd_en   = 1'b1;
        bus.rd_addr = AW'(ph);
        ph = ($urandom_range(0, 15) == 0) ? $urandom_range(0, DEPTH - 1) : (ph + 1) % DEPTH;
      end
      if ($urandom_range(0, 1) == 0) begin
        bus.wr_valid = 1'b1;
        bus.wr_bank  = BW'($urandom_range(0, NB - 1));
        bus.wr_addr  = AW'($urandom_range(0, DEPTH - 1));
        bus.wr_data  = DW'($urandom);
      end
      if ($urandom_range(0, 15) == 0) begin
        bus.bank_sel_valid = 1'b1;
        bus.bank_sel       = BW'($urandom_range(0, NB - 1));
      end
      tick();
    end

    // Reset in the middle of a sweep with a request pending.
    sel((m_active + 1) % NB);
    len = $urandom_range(5, 40);
    for (int a = 200; a < 200 + len; a++) rd(a % DEPTH);
    do_reset();
    for (int a = 0; a < 6; a++) rd(a);
    repeat (4) tick();
    check("rd_queue_drained", exp_rd.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
